// File: rtl/leve1_pkg.sv
// leve1_pkg: shared types for the LEVE1 hazard controller.
// Holds the PC_SEL encodings, controller states and the decode-side issue bundle.
package leve1_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_TRAP   = 2'b10,
        PC_MEPC   = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'b00,
        HZ_FLUSH = 2'b01,
        HZ_DRAIN = 2'b10
    } hz_state_e;

    // Operand/destination view of the instruction sitting in decode.
    typedef struct packed {
        logic              use_rs1;
        logic              use_rs2;
        logic              ll;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } issue_t;

endpackage

// File: rtl/leve1_hazard_ctrl_if.sv
// leve1_hazard_ctrl_if: decode/EX <-> hazard controller signal bundle.
// master = decode/EX/LL-unit side (drives requests), slave = controller.
//   ISSUE_*  : decode request and ISSUE_READY accept
//   LL_DONE/LL_RD : long-latency writeback
//   REDIRECT/TRAP/MRET : EX sequencing events
//   IFLASH/PC_SEL : fetch kill and PC source
//   LL_COUNT/BUSY : outstanding long-latency ops
interface leve1_hazard_ctrl_if #(
    parameter int MAX_LL = 4
);
    import leve1_pkg::*;

    localparam int CW = $clog2(MAX_LL + 1);

    logic              ISSUE_VALID;
    logic [REG_AW-1:0] ISSUE_RS1;
    logic [REG_AW-1:0] ISSUE_RS2;
    logic [REG_AW-1:0] ISSUE_RD;
    logic              ISSUE_USE_RS1;
    logic              ISSUE_USE_RS2;
    logic              ISSUE_LL;
    logic              ISSUE_READY;

    logic              LL_DONE;
    logic [REG_AW-1:0] LL_RD;

    logic              REDIRECT;
    logic              TRAP;
    logic              MRET;

    logic              IFLASH;
    logic [1:0]        PC_SEL;
    logic [CW-1:0]     LL_COUNT;
    logic              BUSY;

    modport master (
        output ISSUE_VALID,
        output ISSUE_RS1,
        output ISSUE_RS2,
        output ISSUE_RD,
        output ISSUE_USE_RS1,
        output ISSUE_USE_RS2,
        output ISSUE_LL,
        input  ISSUE_READY,
        output LL_DONE,
        output LL_RD,
        output REDIRECT,
        output TRAP,
        output MRET,
        input  IFLASH,
        input  PC_SEL,
        input  LL_COUNT,
        input  BUSY
    );

    modport slave (
        input  ISSUE_VALID,
        input  ISSUE_RS1,
        input  ISSUE_RS2,
        input  ISSUE_RD,
        input  ISSUE_USE_RS1,
        input  ISSUE_USE_RS2,
        input  ISSUE_LL,
        output ISSUE_READY,
        input  LL_DONE,
        input  LL_RD,
        input  REDIRECT,
        input  TRAP,
        input  MRET,
        output IFLASH,
        output PC_SEL,
        output LL_COUNT,
        output BUSY
    );

endinterface

// File: rtl/leve1_scoreboard.sv
// leve1_scoreboard: long-latency register scoreboard, occupancy counter
// and hazard lookup. Optional macro LEVE1_LL_BYPASS_EN lets a same-cycle
// writeback release its dependents.
//   CLK, RSTn      : clock, async active-low reset
//   issue_i        : decode operands/destination
//   fire_i         : instruction accepted this cycle
//   ll_done_i/ll_rd_i : long-latency writeback
//   hazard_o       : issue must stall
//   ll_count_o     : outstanding long-latency ops
module leve1_scoreboard
    import leve1_pkg::*;
#(
    parameter  int NUM_REG = 32,
    parameter  int MAX_LL  = 4,
    localparam int CW      = $clog2(MAX_LL + 1)
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  issue_t            issue_i,
    input  logic              fire_i,
    input  logic              ll_done_i,
    input  logic [REG_AW-1:0] ll_rd_i,
    output logic              hazard_o,
    output logic [CW-1:0]     ll_count_o
);

    logic [NUM_REG-1:0] sb_q;
    logic [NUM_REG-1:0] sb_d;
    logic [NUM_REG-1:0] set_vec;
    logic [NUM_REG-1:0] clr_vec;
    logic [NUM_REG-1:0] sb_view;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic [CW-1:0]      cnt_view;
    logic               done_ok;
    logic               ll_fire;

    // A writeback with nothing outstanding is spurious and ignored.
    assign done_ok = ll_done_i && (cnt_q != '0);
    assign ll_fire = fire_i && issue_i.ll;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (ll_fire && (issue_i.rd != '0)) begin
            set_vec[issue_i.rd] = 1'b1;
        end
        if (done_ok && (ll_rd_i != '0)) begin
            clr_vec[ll_rd_i] = 1'b1;
        end
    end

    // Set is applied after clear so a same-register collision stays pending.
    assign sb_d = (sb_q & ~clr_vec) | set_vec;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({ll_fire, done_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef LEVE1_LL_BYPASS_EN
    // The writeback is forwarded by the datapath, so its register and
    // its occupancy slot are already free for this cycle's lookup.
    assign sb_view  = sb_q & ~clr_vec;
    assign cnt_view = cnt_q - CW'(done_ok);
`else
    assign sb_view  = sb_q;
    assign cnt_view = cnt_q;
`endif

    assign hazard_o = (issue_i.use_rs1 && sb_view[issue_i.rs1])
                   || (issue_i.use_rs2 && sb_view[issue_i.rs2])
                   || (issue_i.ll && sb_view[issue_i.rd])
                   || (issue_i.ll && (cnt_view == CW'(MAX_LL)));

    assign ll_count_o = cnt_q;

endmodule

// File: rtl/leve1_hazard_ctrl.sv
// leve1_hazard_ctrl: LEVE1 issue throttle and fetch-flush sequencer.
// Optional macro LEVE1_LL_BYPASS_EN (see leve1_scoreboard).
//   CLK, RSTn : clock, async active-low reset
//   bus       : leve1_hazard_ctrl_if.slave (issue handshake, LL
//               writeback, EX events, IFLASH/PC_SEL, LL_COUNT/BUSY)
// IFLASH and PC_SEL are registered; ISSUE_READY is combinational.
module leve1_hazard_ctrl
    import leve1_pkg::*;
#(
    parameter int NUM_REG      = 32,
    parameter int MAX_LL       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                CLK,
    input logic                RSTn,
    leve1_hazard_ctrl_if.slave bus
);

    localparam int CW = $clog2(MAX_LL + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    localparam logic [1:0] S_RUN   = HZ_RUN;
    localparam logic [1:0] S_FLUSH = HZ_FLUSH;
    localparam logic [1:0] S_DRAIN = HZ_DRAIN;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [FW-1:0] fcnt_q;
    logic [FW-1:0] fcnt_d;
    logic          iflash_q;
    logic          iflash_d;
    logic [1:0]    pcsel_q;
    logic [1:0]    pcsel_d;

    issue_t        iss;
    logic          fire;
    logic          hazard;
    logic [CW-1:0] ll_count;
    logic          any_ev;
    logic          trap_ev;
    logic          mret_ev;
    logic          redir_ev;

    assign iss = '{
        use_rs1: bus.ISSUE_USE_RS1,
        use_rs2: bus.ISSUE_USE_RS2,
        ll:      bus.ISSUE_LL,
        rs1:     bus.ISSUE_RS1,
        rs2:     bus.ISSUE_RS2,
        rd:      bus.ISSUE_RD
    };

    leve1_scoreboard #(
        .NUM_REG (NUM_REG),
        .MAX_LL  (MAX_LL)
    ) u_sb (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .issue_i    (iss),
        .fire_i     (fire),
        .ll_done_i  (bus.LL_DONE),
        .ll_rd_i    (bus.LL_RD),
        .hazard_o   (hazard),
        .ll_count_o (ll_count)
    );

    // Priority-resolved, mutually exclusive event strobes.
    assign trap_ev  = bus.TRAP;
    assign mret_ev  = bus.MRET && !bus.TRAP;
    assign redir_ev = bus.REDIRECT && !bus.TRAP && !bus.MRET;
    assign any_ev   = bus.TRAP || bus.MRET || bus.REDIRECT;

    // An event in EX kills the decode slot in the same cycle.
    assign bus.ISSUE_READY = (state_q == S_RUN) && !hazard && !any_ev;

    assign fire = bus.ISSUE_VALID && bus.ISSUE_READY;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        iflash_d = iflash_q;
        pcsel_d  = PC_SEQ;
        unique case (state_q)
            S_RUN: begin
                iflash_d = 1'b0;
                unique case (1'b1)
                    trap_ev: begin
                        iflash_d = 1'b1;
                        if (ll_count == '0) begin
                            state_d = S_FLUSH;
                            fcnt_d  = FLUSH_LOAD;
                            pcsel_d = PC_TRAP;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                    mret_ev: begin
                        state_d  = S_FLUSH;
                        fcnt_d   = FLUSH_LOAD;
                        iflash_d = 1'b1;
                        pcsel_d  = PC_MEPC;
                    end
                    redir_ev: begin
                        state_d  = S_FLUSH;
                        fcnt_d   = FLUSH_LOAD;
                        iflash_d = 1'b1;
                        pcsel_d  = PC_BRANCH;
                    end
                    default: begin
                        state_d = S_RUN;
                    end
                endcase
            end
            S_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d  = S_RUN;
                    iflash_d = 1'b0;
                end else begin
                    fcnt_d   = fcnt_q - FW'(1);
                    iflash_d = 1'b1;
                end
            end
            S_DRAIN: begin
                // Trap vector is taken only once every older LL op has
                // written back, so precise state is visible to the handler.
                iflash_d = 1'b1;
                if (ll_count == '0) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                    pcsel_d = PC_TRAP;
                end
            end
            default: begin
                state_d  = S_RUN;
                iflash_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_RUN;
            fcnt_q   <= '0;
            iflash_q <= 1'b0;
            pcsel_q  <= PC_SEQ;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            iflash_q <= iflash_d;
            pcsel_q  <= pcsel_d;
        end
    end

    assign bus.IFLASH   = iflash_q;
    assign bus.PC_SEL   = pcsel_q;
    assign bus.LL_COUNT = ll_count;
    assign bus.BUSY     = (ll_count != '0);

endmodule

// File: doc/leve1_hazard_ctrl.md
# leve1_hazard_ctrl

Pipeline sequencing controller for the LEVE1 core. It sits beside the decode/register-read stage. It keeps a register scoreboard for long-latency writebacks (load, mul/div) and throttles issue on RAW, WAW and occupancy hazards. It also sequences redirect, trap and mret flushes toward fetch by driving `IFLASH` and a PC-source select.

## Interface
- `NUM_REG`, 32, architectural integer registers; x0 is never tracked.
- `MAX_LL`, 4, maximum outstanding long-latency ops.
- `FLUSH_CYCLES`, 2, IFLASH pulse length per redirect (≥1).
- `CLK  in  1  clock`
- `RSTn  in  1  reset, asynchronous, active-low`
- `ISSUE_VALID  in  1  decode holds a valid instruction`
- `ISSUE_RS1 / ISSUE_RS2 / ISSUE_RD  in  5 each  register indices`
- `ISSUE_USE_RS1 / ISSUE_USE_RS2  in  1 each  operand actually read`
- `ISSUE_LL  in  1  instruction writes rd through a long-latency unit`
- `ISSUE_READY  out  1  issue accepted this cycle (fire = VALID&&READY)`
- `LL_DONE  in  1  long-latency unit writes back this cycle`
- `LL_RD  in  5  writeback register for LL_DONE`
- `REDIRECT  in  1  EX resolved a taken branch or jump`
- `TRAP  in  1  EX raised an exception`
- `MRET  in  1  EX retires mret`
- `IFLASH  out  1  kill fetch/decode contents`
- `PC_SEL  out  2  00 sequential, 01 branch target, 10 trap vector, 11 mepc`
- `LL_COUNT  out  $clog2(MAX_LL+1)  outstanding long-latency ops`
- `BUSY  out  1  LL_COUNT != 0`

## Operation
- Scoreboard `sb[NUM_REG-1:1]`: set on a fire with ISSUE_LL and rd≠0; cleared on LL_DONE for LL_RD≠0.
  - If set and clear hit the same register in one cycle, set wins.
- `LL_COUNT`: +1 on an LL fire, −1 on LL_DONE, unchanged when both occur.
  - LL_DONE while count=0 is ignored; count and sb are unchanged.
- Hazard: (USE_RS1 && sb[rs1]) || (USE_RS2 && sb[rs2]) || (ISSUE_LL && sb[rd]) || (ISSUE_LL && LL_COUNT==MAX_LL).
- `ISSUE_READY` = state==RUN && !hazard && !REDIRECT && !TRAP && !MRET. It is combinational.
- FSM states: RUN, FLUSH, DRAIN.
  - RUN with an event: priority TRAP > MRET > REDIRECT.
    - REDIRECT or MRET → FLUSH, with PC_SEL 01 or 11 respectively.
    - TRAP with LL_COUNT==0 → FLUSH, PC_SEL=10.
    - TRAP with outstanding ops → DRAIN.
  - DRAIN: IFLASH=1 and ISSUE_READY=0. When LL_COUNT reaches 0 → FLUSH, PC_SEL=10.
  - FLUSH: a counter runs FLUSH_CYCLES, then → RUN.
  - REDIRECT, TRAP and MRET are ignored in FLUSH and DRAIN, since they come from squashed instructions.
- Scoreboard clears continue in every state.

## Timing
- Reset values: state=RUN, sb=0, LL_COUNT=0, IFLASH=0, PC_SEL=00, BUSY=0.
- IFLASH and PC_SEL are registered. For an event sampled at cycle t that goes straight to FLUSH:
  - PC_SEL is non-zero exactly at cycle t+1.
  - IFLASH is high for cycles t+1 .. t+FLUSH_CYCLES.
  - ISSUE_READY may return at t+FLUSH_CYCLES+1.
- DRAIN: IFLASH is high from t+1. PC_SEL=10 appears the cycle after LL_COUNT is seen as 0, followed by the full FLUSH pulse.
- Without the bypass option, an instruction that depends on LL_RD can issue no earlier than the cycle after LL_DONE.
- Reset asserted mid-flush or mid-drain returns the block to reset values immediately.

## Configuration
- `LEVE1_LL_BYPASS_EN` defined: an LL_DONE in the current cycle masks `sb[LL_RD]` in the hazard term, and the occupancy check uses count−LL_DONE. A dependent instruction issues in the same cycle as the writeback, with the data forwarded by the datapath.
- Macro undefined: the hazard term uses only registered sb and count, adding a one-cycle bubble.

## Structure
- Shared package `leve1_pkg`: `pc_sel_e` (PC_SEL encodings) and `hz_state_e` (RUN/FLUSH/DRAIN).
- One sub-module, `leve1_scoreboard`: the sb vector, the LL_COUNT counter and the hazard lookup.
- The FSM and flush counter stay in the top module.

## Test plan
- LL issue rd=5; next instruction reads x5 → ISSUE_READY=0 until LL_DONE(5). Issue occurs in the LL_DONE cycle with bypass, one cycle later without.
- Four LL issues to x1–x4, then a fifth LL → stalled at LL_COUNT=4. An LL_DONE releases it; simultaneous fire+done keeps the count at 4.
- REDIRECT at cycle 10 → PC_SEL=01 at 11, IFLASH at 11–12, ISSUE_READY at 13.
- TRAP with 2 ops outstanding → DRAIN. LL_DONEs at +3 and +5 → PC_SEL=10 one cycle after the count reaches 0, then a 2-cycle flush.
- TRAP+MRET+REDIRECT in the same cycle → PC_SEL=10. A REDIRECT during FLUSH is ignored.
- LL_DONE with count 0 → no change. RSTn low during DRAIN → all outputs return to reset values asynchronously.
